// File: rtl/toggle_event_rx_pkg.sv
// -----------------------------------------------------------------------------
// toggle_link_pkg
//   Shared constants and helpers for both ends of a toggle-signalling link.
//   - DEF_SYNC_STAGES / DEF_PEND_W / DEF_TOTAL_W : default receiver sizing
//   - MIN_TOGGLE_GAP : minimum clk cycles the sender must hold a level
//   - pend_op_e / pend_op() : per-cycle action on the pending-event counter
// -----------------------------------------------------------------------------
package toggle_link_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_PEND_W      = 4;
  localparam int DEF_TOTAL_W     = 16;

  // A level must survive the synchronizer plus the previous-level register.
  localparam int MIN_TOGGLE_GAP  = DEF_SYNC_STAGES + 1;

  // Width of the post-reset priming counter (enough for SYNC_STAGES up to 4).
  localparam int PRIME_W         = 3;

  typedef enum logic [1:0] {
    PEND_HOLD = 2'd0,
    PEND_INC  = 2'd1,
    PEND_DEC  = 2'd2,
    PEND_DROP = 2'd3
  } pend_op_e;

  // Event arrival and acceptance in the same cycle cancel out, even when full.
  function automatic pend_op_e pend_op(input logic det, input logic acc, input logic full);
    pend_op_e op;
    if (det && !acc) begin
      if (full) begin
        op = PEND_DROP;
      end else begin
        op = PEND_INC;
      end
    end else if (!det && acc) begin
      op = PEND_DEC;
    end else begin
      op = PEND_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/toggle_event_rx_if.sv
// -----------------------------------------------------------------------------
// toggle_event_rx_if
//   Consumer-side event interface of the toggle receiver.
//   evt_pulse   : 1-cycle pulse per detected toggle
//   evt_valid   : pending count is non-zero
//   evt_ready   : consumer takes one event when evt_valid & evt_ready
//   pending     : events detected but not yet accepted
//   total_count : events detected since reset (wrapping)
//   overflow    : sticky, an event was lost because pending was full
//   ovf_clr     : clears overflow
//   master = receiver (drives the event side), slave = consumer.
// -----------------------------------------------------------------------------
interface toggle_event_rx_if
  import toggle_link_pkg::*;
#(
  parameter int PEND_W  = DEF_PEND_W,
  parameter int TOTAL_W = DEF_TOTAL_W
) ();

  logic               evt_pulse;
  logic               evt_valid;
  logic               evt_ready;
  logic [PEND_W-1:0]  pending;
  logic [TOTAL_W-1:0] total_count;
  logic               overflow;
  logic               ovf_clr;

  modport master (
    output evt_pulse, evt_valid, pending, total_count, overflow,
    input  evt_ready, ovf_clr
  );

  modport slave (
    input  evt_pulse, evt_valid, pending, total_count, overflow,
    output evt_ready, ovf_clr
  );

endinterface

// File: rtl/toggle_event_rx_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Multi-flop synchronizer for a single asynchronous input, cleared to 0.
//   clk   : destination clock
//   reset : synchronous, active-high
//   d     : asynchronous input
//   q     : synchronized output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the input through the synchronizer flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// -----------------------------------------------------------------------------
// toggle_event_rx
//   Receive end of a toggle link: every level flip of toggle_in becomes one
//   event, queued as a pending count and offered over valid/ready.
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high, clears all state
//   toggle_in : toggle line from the sender, may be asynchronous
//   evt       : event interface (master side), see toggle_event_rx_if
// -----------------------------------------------------------------------------
module toggle_event_rx
  import toggle_link_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int PEND_W      = DEF_PEND_W,
  parameter int TOTAL_W     = DEF_TOTAL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               toggle_in,
  toggle_event_rx_if.master  evt
);

  // Priming lasts SYNC_STAGES+1 cycles: the counter runs 0..SYNC_STAGES.
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);
  localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};

  logic               sync_out_s;
  logic               tgl_prev_r;
  logic               primed_r;
  logic [PRIME_W-1:0] prime_cnt_r;
  logic               det_s;
  logic               acc_s;
  logic               valid_s;
  pend_op_e           op_s;
  logic [PEND_W-1:0]  pending_r;
  logic [PEND_W-1:0]  pending_nxt_s;
  logic [TOTAL_W-1:0] total_r;
  logic               evt_pulse_r;
  logic               overflow_r;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (toggle_in),
    .q     (sync_out_s)
  );

  // Hold off detection until the link's idle level has reached tgl_prev.
  always_ff @(posedge clk) begin
    if (reset) begin
      prime_cnt_r <= {PRIME_W{1'b0}};
      primed_r    <= 1'b0;
    end else if (!primed_r) begin
      prime_cnt_r <= prime_cnt_r + {{(PRIME_W-1){1'b0}}, 1'b1};
      primed_r    <= (prime_cnt_r == PRIME_LAST);
    end else begin
      prime_cnt_r <= prime_cnt_r;
      primed_r    <= 1'b1;
    end
  end

  // Edge detect, acceptance and pending-counter decision.
  always_comb begin
    det_s         = 1'b0;
    if (primed_r) begin
      det_s = sync_out_s ^ tgl_prev_r;
    end else begin
      det_s = 1'b0;
    end
    valid_s       = (pending_r != {PEND_W{1'b0}});
    acc_s         = valid_s & evt.evt_ready;
    op_s          = pend_op(det_s, acc_s, (pending_r == PEND_MAX));
    pending_nxt_s = pending_r;
    case (op_s)
      PEND_INC: pending_nxt_s = pending_r + {{(PEND_W-1){1'b0}}, 1'b1};
      PEND_DEC: pending_nxt_s = pending_r - {{(PEND_W-1){1'b0}}, 1'b1};
      default:  pending_nxt_s = pending_r;
    endcase
  end

  // Event state: previous level, pulse, counters and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgl_prev_r  <= 1'b0;
      evt_pulse_r <= 1'b0;
      pending_r   <= {PEND_W{1'b0}};
      total_r     <= {TOTAL_W{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      tgl_prev_r  <= sync_out_s;
      evt_pulse_r <= det_s;
      pending_r   <= pending_nxt_s;
      // Dropped events are still counted in the total.
      if (det_s) begin
        total_r <= total_r + {{(TOTAL_W-1){1'b0}}, 1'b1};
      end else begin
        total_r <= total_r;
      end
      // A new drop wins over a clear so no loss goes unreported.
      if (op_s == PEND_DROP) begin
        overflow_r <= 1'b1;
      end else if (evt.ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign evt.evt_pulse   = evt_pulse_r;
  assign evt.evt_valid   = valid_s;
  assign evt.pending     = pending_r;
  assign evt.total_count = total_r;
  assign evt.overflow    = overflow_r;

endmodule
